// File: rtl/sample_chunk_packer_if.sv
// AXI-stream style bus (valid/ready/data/last) shared by the sample input and chunk output sides.
interface sample_chunk_packer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input  tready);
  modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/sample_chunk_packer.sv
// Packs samples into chunk words (tlast flushes a padded partial chunk) and records instrument start
// addresses; chunk appears 1 cycle after its closing sample, input stalls only while an output chunk is blocked.
module sample_chunk_packer #(
  parameter int                      INSTRUMENT_COUNT = 8,
  parameter int                      SAMPLE_WIDTH     = 16,
  parameter int                      CHUNK_WIDTH      = 128,
  parameter int                      ADDR_WIDTH       = 24,
  parameter logic [SAMPLE_WIDTH-1:0] PAD_VALUE        = '0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  sample_chunk_packer_if.slave                      sample_axis,
  sample_chunk_packer_if.master                     chunk_axis,
  output logic [INSTRUMENT_COUNT:0][ADDR_WIDTH-1:0] addr_starts,
  output logic                                      done,
  output logic                                      overflow
);
  localparam int LANES  = CHUNK_WIDTH / SAMPLE_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IDX_W  = $clog2(INSTRUMENT_COUNT + 1);

  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [IDX_W-1:0]      LAST_INST = IDX_W'(INSTRUMENT_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX   = '1;

  typedef logic [LANES-1:0][SAMPLE_WIDTH-1:0] chunk_t;
  typedef enum logic {ST_PACK, ST_DONE} state_t;

  state_t                                    state_q, state_d;
  logic [LANE_W-1:0]                         lane_q, lane_d;
  chunk_t                                    acc_q, acc_d;
  chunk_t                                    out_dat_q, out_dat_d;
  logic                                      out_vld_q, out_vld_d;
  logic                                      out_last_q, out_last_d;
  logic [IDX_W-1:0]                          inst_q, inst_d;
  logic [ADDR_WIDTH-1:0]                     cnt_q, cnt_d;
  logic [INSTRUMENT_COUNT:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                                      done_q, done_d;
  logic                                      ovf_q, ovf_d;

  logic   in_rdy;
  logic   pack_en;
  logic   in_fire;
  logic   pack_fire;
  logic   close;
  logic   last_inst_close;
  chunk_t formed;

  assign in_fire         = sample_axis.tvalid && in_rdy;
  assign pack_fire       = in_fire && pack_en;
  assign close           = pack_fire && ((lane_q == LAST_LANE) || sample_axis.tlast);
  assign last_inst_close = close && sample_axis.tlast && (inst_q == LAST_INST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PACK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PACK: if (last_inst_close) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_PACK;
    endcase
  end

  // In DONE every sample is swallowed so the upstream parser never wedges on surplus data.
  always_comb begin
    in_rdy  = 1'b1;
    pack_en = 1'b0;
    case (state_q)
      ST_PACK: begin
        in_rdy  = !out_vld_q || chunk_axis.tready;
        pack_en = 1'b1;
      end
      ST_DONE: begin
        in_rdy  = 1'b1;
        pack_en = 1'b0;
      end
      default: begin
        in_rdy  = 1'b1;
        pack_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    formed = '0;
    for (int i = 0; i < LANES; i++) begin
      if (LANE_W'(i) < lane_q) begin
        formed[i] = acc_q[i];
      end else if (LANE_W'(i) == lane_q) begin
        formed[i] = sample_axis.tdata;
      end else begin
        formed[i] = PAD_VALUE;
      end
    end
  end

  always_comb begin
    lane_d     = lane_q;
    acc_d      = acc_q;
    out_dat_d  = out_dat_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    inst_d     = inst_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    done_d     = done_q;
    ovf_d      = ovf_q;

    if (pack_fire && !close) begin
      acc_d[lane_q] = sample_axis.tdata;
      lane_d        = lane_q + LANE_W'(1);
    end

    if (close) begin
      lane_d     = '0;
      out_vld_d  = 1'b1;
      out_dat_d  = formed;
      out_last_d = sample_axis.tlast;
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
      end
      // cnt_d already points past this chunk, i.e. at the next instrument's first chunk.
      if (sample_axis.tlast) begin
        addr_d[inst_q + IDX_W'(1)] = cnt_d;
        inst_d                     = inst_q + IDX_W'(1);
        if (inst_q == LAST_INST) begin
          done_d = 1'b1;
        end
      end
    end else if (chunk_axis.tready) begin
      out_vld_d = 1'b0;
    end

    if (in_fire && !pack_en) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q     <= '0;
      acc_q      <= '0;
      out_dat_q  <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      inst_q     <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      out_dat_q  <= out_dat_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      inst_q     <= inst_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign sample_axis.tready = in_rdy;
  assign chunk_axis.tvalid  = out_vld_q;
  assign chunk_axis.tdata   = out_dat_q;
  assign chunk_axis.tlast   = out_last_q;

  always_comb begin
    addr_starts    = addr_q;
    addr_starts[0] = '0;
  end

  assign done     = done_q;
  assign overflow = ovf_q;
endmodule
